waiz_feature_loader: RTL and testbench
======================================

// Module: waiz_feature_loader
// PURPOSE
//  Upstream input stage for the jet-tagging batchnorm network core.
//  - Accepts a serial stream of signed fixed-point features over a valid/ready handshake.
//  - Assembles INPUT_SIZE features into the parallel input_data frame and strobes the core's input_ready.
//  - Holds the frame stable and stalls the stream until the core's output_ready rises.
//  - Flags malformed frames by s_last position.
// PARAMETERS
//  WIDTH       4   bits per feature, signed two's complement, NFRAC-agnostic pass-through
//  INPUT_SIZE  16  features per frame (>=2); index width IW = $clog2(INPUT_SIZE)
//  CNT_WIDTH   16  width of frames_done counter
// PORTS
//  clk          in   1                 single clock, rising edge
//  reset_n      in   1                 asynchronous, active-low reset
//  s_valid      in   1                 stream word valid
//  s_ready      out  1                 stream word accepted when s_valid && s_ready
//  s_data       in   WIDTH             signed feature
//  s_last       in   1                 marks the final feature of a frame
//  input_data   out  WIDTH x INPUT_SIZE  assembled frame, element k = k-th accepted word
//  input_ready  out  1                 one-cycle strobe to core: frame valid
//  output_ready in   1                 core done (level or pulse; rising edge is used)
//  frame_err    out  1                 sticky: s_last mismatch seen
//  frames_done  out  CNT_WIDTH         frames issued to core, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  - Reset (async assert, sync-released use): state=FILL, idx=0, input_data all 0, input_ready=0,
//    frame_err=0, frames_done=0, or_q (registered output_ready)=0.
//  - s_ready = (state==FILL), combinational from state; it is 1 in the first cycle after reset.
//  - FILL: on each accept, input_data[idx] <= s_data and idx increments.
//    - Accept with idx==INPUT_SIZE-1: idx<=0, state<=ISSUE. If s_last==0, set frame_err.
//    - Accept with s_last==1 and idx<INPUT_SIZE-1 (early last): drop the partial frame.
//      idx<=0, set frame_err, stay in FILL. Already-written input_data words are not cleared.
//  - ISSUE (1 cycle): input_ready=1, frames_done++, state<=WAIT. output_ready is ignored here.
//  - WAIT: s_ready=0; input_data held stable. Rising edge (output_ready && !or_q) -> state<=FILL.
//  - or_q is updated every cycle in every state.
//    - output_ready already high on entry to WAIT is not an edge; the loader waits for the next rising edge.
//  - Latency: final word accepted at cycle T -> input_ready=1 and complete input_data at T+1.
//    - Next word acceptable in the cycle after the rising edge is sampled.
//    - Minimum frame period is INPUT_SIZE+2 cycles plus core latency.
//  - input_ready is registered and never high for two consecutive cycles.
//  - frame_err is cleared only by reset_n. frames_done wraps from 2^CNT_WIDTH-1 to 0.
//  - s_data is sampled only on accept. s_valid while s_ready=0 has no effect and need not be held.
//  - Reset mid-frame or mid-WAIT: immediate return to reset values; the partial frame is lost.
//  - Illegal state encoding recovers to FILL.
// TESTING
//  1. Reset, stream 16 words 0..7,-8..-1 with s_last on word 15, back-to-back valid.
//     -> s_ready=1 for 16 cycles; input_ready pulses 1 cycle after word 15;
//        input_data[k] matches word k; frames_done=1; frame_err=0.
//  2. In WAIT, hold output_ready high from before entry.
//     -> no return to FILL; drop then raise output_ready -> s_ready=1 the next cycle.
//  3. s_last on word 5.
//     -> no input_ready; frame_err=1; the next 16-word frame issues correctly; frame_err stays 1.
//  4. 16 words with no s_last.
//     -> input_ready pulses; frame_err=1; frames_done increments.
//  5. Randomly gap s_valid (50%) over 3 frames with the core replying after 7 cycles.
//     -> frames match a scoreboard; frames_done=3; input_data is stable throughout WAIT.
//  6. Assert reset_n low at word 9, then release and send a full frame.
//     -> outputs at reset values during reset; the issued frame contains only post-reset words.

Source files
------------

// File: rtl/waiz_feature_loader.sv
// Serial-to-parallel feature loader feeding the jet-tagging batchnorm core.
// Collects INPUT_SIZE stream words into one frame, strobes the core, then waits for its rising done.
module waiz_feature_loader #(
  parameter int WIDTH      = 4,
  parameter int INPUT_SIZE = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic signed [WIDTH-1:0]              s_data,
  input  logic                                 s_last,
  output logic [INPUT_SIZE-1:0][WIDTH-1:0]     input_data,
  output logic                                 input_ready,
  input  logic                                 output_ready,
  output logic                                 frame_err,
  output logic [CNT_WIDTH-1:0]                 frames_done
);

  localparam int IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(INPUT_SIZE - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            or_q;
  logic            accept;

  assign s_ready = (state == S_FILL);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_FILL;
      idx         <= '0;
      input_data  <= '0;
      input_ready <= 1'b0;
      frame_err   <= 1'b0;
      frames_done <= '0;
      or_q        <= 1'b0;
    end else begin
      or_q        <= output_ready;
      input_ready <= 1'b0;
      case (state)
        S_FILL: begin
          if (accept) begin
            input_data[idx] <= s_data;
            if (idx == LAST_IDX) begin
              // Strobe is launched here so it lines up with the ISSUE cycle.
              idx         <= '0;
              state       <= S_ISSUE;
              input_ready <= 1'b1;
              if (!s_last) frame_err <= 1'b1;
            end else if (s_last) begin
              // Early last: discard the partial frame, stale words are simply overwritten later.
              idx       <= '0;
              frame_err <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          frames_done <= frames_done + 1'b1;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          // Only a fresh rising edge releases the frame; a level held since ISSUE does not.
          if (output_ready && !or_q) state <= S_FILL;
        end
        default: begin
          state <= S_FILL;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_waiz_feature_loader.sv
// Scoreboard bench for waiz_feature_loader: driver feeds a frame-level model, monitor checks each issued frame.
module tb_waiz_feature_loader;

  localparam int W  = 4;
  localparam int N  = 16;
  localparam int CW = 3;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  s_valid = 1'b0;
  logic                  s_ready;
  logic [W-1:0]          s_data = '0;
  logic                  s_last = 1'b0;
  logic [N-1:0][W-1:0]   input_data;
  logic                  input_ready;
  logic                  output_ready = 1'b0;
  logic                  frame_err;
  logic [CW-1:0]         frames_done;

  waiz_feature_loader #(.WIDTH(W), .INPUT_SIZE(N), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .input_data(input_data),
    .input_ready(input_ready), .output_ready(output_ready),
    .frame_err(frame_err), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0][W-1:0] data;
    bit                  err;
    int                  fd;
    int                  acc_cyc;
  } exp_t;
  exp_t q[$];

  // Frame-level reference: words land at their frame position; a frame completes on its N-th word.
  logic [N-1:0][W-1:0] m_buf = '0;
  int m_idx = 0;
  bit m_err = 0;
  int m_fd  = 0;
  int acc_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_accept(input logic [W-1:0] d, input bit last);
    exp_t e;
    m_buf[m_idx] = d;
    if (m_idx == N - 1) begin
      m_err = m_err | !last;
      m_fd  = (m_fd + 1) % (1 << CW);
      e.data = m_buf; e.err = m_err; e.fd = m_fd; e.acc_cyc = cyc;
      q.push_back(e);
      m_idx = 0;
    end else if (last) begin
      m_err = 1;
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic send_word(input logic [W-1:0] d, input bit last, input int gap);
    bit done = 0;
    int n = 0;
    while (!done) begin
      @(negedge clk);
      s_data  = d;
      s_last  = last;
      s_valid = ($urandom_range(99) >= gap);
      if (s_valid && s_ready) begin
        done = 1;
        acc_cyc = cyc;
        model_accept(d, last);
      end else if (++n > 500) begin
        checks++; failures++;
        $display("FAIL accept_timeout: word not accepted within 500 cycles");
        done = 1;
      end
    end
  endtask

  // last_pos < 0 means no s_last in the frame; seq selects the counting pattern instead of random data.
  task automatic send_frame(input int nw, input int last_pos, input int gap, input bit seq);
    for (int i = 0; i < nw; i++)
      send_word(seq ? W'(i) : W'($urandom), (i == last_pos), gap);
  endtask

  task automatic core_reply(input int delay);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      s_valid = $urandom_range(1);
      s_data  = W'($urandom);
      s_last  = $urandom_range(1);
      chk("wait_s_ready_low", s_ready, 0);
    end
    output_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    chk("s_ready_after_edge", s_ready, 1);
    output_ready = 1'b0;
  endtask

  logic [N-1:0][W-1:0] cap;
  bit have = 0;
  bit pend = 0;
  int pend_fd = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      have = 0;
      pend = 0;
    end else begin
      if (pend) begin
        chk("frames_done", frames_done, pend_fd);
        chk("input_ready_one_cycle", input_ready, 0);
        pend = 0;
      end
      if (input_ready) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_input_ready: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("frame_data", input_data, e.data);
          chk("frame_err_at_issue", frame_err, e.err);
          chk("issue_latency", cyc, e.acc_cyc + 1);
          cap = input_data;
          have = 1;
          pend = 1;
          pend_fd = e.fd;
        end
      end else if (have) begin
        if (s_ready) have = 0;
        else chk("wait_data_stable", input_data, cap);
      end
    end
  end

  initial begin
    int first_cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_input_ready", input_ready, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_frames_done", frames_done, 0);
    chk("rst_input_data", input_data, 0);
    reset_n = 1'b1;

    // Counting frame, back-to-back.
    send_word(W'(0), 1'b0, 0);
    first_cyc = acc_cyc;
    for (int i = 1; i < N; i++) send_word(W'(i), (i == N - 1), 0);
    chk("t1_back_to_back", acc_cyc - first_cyc, N - 1);
    core_reply(7);
    chk("t1_frame_err", frame_err, 0);

    // output_ready held high before WAIT is entered.
    output_ready = 1'b1;
    send_frame(N, N - 1, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_valid = 1'b0;
      chk("t2_held_high_no_release", s_ready, 0);
    end
    @(negedge clk);
    output_ready = 1'b0;
    @(negedge clk);
    chk("t2_still_waiting", s_ready, 0);
    output_ready = 1'b1;
    @(negedge clk);
    chk("t2_s_ready_after_edge", s_ready, 1);
    output_ready = 1'b0;

    // Full frame without s_last.
    send_frame(N, -1, 0, 1'b0);
    core_reply(4);
    chk("t4_frame_err", frame_err, 1);

    // Early last at word 5, then a clean frame.
    send_frame(6, 5, 0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    chk("t3_frame_err_set", frame_err, 1);
    chk("t3_s_ready_stays", s_ready, 1);
    send_frame(N, N - 1, 30, 1'b0);
    core_reply(3);
    chk("t3_frame_err_sticky", frame_err, 1);

    // Gapped random frames; counter wraps at 2^CW.
    for (int f = 0; f < 5; f++) begin
      send_frame(N, N - 1, 50, 1'b0);
      core_reply(7);
    end
    chk("t5_frames_done", frames_done, m_fd);

    // Reset in the middle of a frame.
    send_frame(9, -1, 0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    s_valid = 1'b0;
    m_idx = 0; m_err = 0; m_fd = 0; m_buf = '0;
    q.delete();
    #1;
    chk("t6_rst_s_ready", s_ready, 1);
    chk("t6_rst_input_ready", input_ready, 0);
    chk("t6_rst_frame_err", frame_err, 0);
    chk("t6_rst_frames_done", frames_done, 0);
    chk("t6_rst_input_data", input_data, 0);
    repeat (2) @(negedge clk);
    chk("t6_rst_held_data", input_data, 0);
    reset_n = 1'b1;
    send_frame(N, N - 1, 20, 1'b0);
    core_reply(5);
    chk("t6_frame_err", frame_err, 0);
    chk("t6_frames_done", frames_done, 1);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
